fast_serial_link: RTL and testbench
===================================

// Module: fast_serial_link
// PURPOSE
//  Parametrised FTDI fast-opto serial transceiver: generates FSCLK, serialises TX bytes to FSDI (gated by FSCTS),
//  deserialises FSDO to bytes. Buffers both directions in FIFOs with stream handshakes.
//  Successor to the separate clock/rx/tx fast-serial blocks; feeds the Avalon byte-stream bridge.
// PARAMETERS
//  CLK_DIV  4  i_clk cycles per FSCLK period; even, >=4; high and low halves CLK_DIV/2 each
//  TX_AW    4  TX FIFO address width; depth 2**TX_AW
//  RX_AW    4  RX FIFO address width; depth 2**RX_AW
//  TX_PORT  0  source bit sent in every TX frame (0=channel A, 1=channel B)
// PORTS
//  i_clk          in   1  system clock
//  i_reset        in   1  synchronous, active-high reset
//  i_tx_data      in   8  TX byte
//  i_tx_valid     in   1  TX byte valid
//  o_tx_ready     out  1  TX FIFO not full; write when valid&ready
//  o_tx_busy      out  1  TX FIFO non-empty or frame in progress
//  o_rx_data      out  8  RX byte (FIFO head)
//  o_rx_src       out  1  source bit of RX byte
//  o_rx_valid     out  1  RX FIFO non-empty
//  i_rx_ready     in   1  consumer accepts; pop when valid&ready
//  o_rx_overflow  out  1  sticky: frame dropped, RX FIFO full; cleared only by reset
//  o_fsclk        out  1  FSCLK to FTDI
//  o_fsdi         out  1  FSDI to FTDI
//  i_fsdo         in   1  FSDO from FTDI (async)
//  i_fscts        in   1  FSCTS from FTDI (async)
//  i_loopback     in   1  loopback select (used only with FAST_SERIAL_LOOPBACK_EN)
// BEHAVIOUR
//  Reset values: o_fsclk=0, o_fsdi=1, o_rx_valid=0, o_rx_overflow=0, o_tx_busy=0, o_tx_ready=1; FIFOs empty; FSMs idle; divider=0.
//  Reset mid-frame aborts the frame; o_fsdi=1 on the next edge; partial RX byte discarded.
//  Divider: counter 0..CLK_DIV-1. rise_tick = cycle o_fsclk goes 0->1. fall_tick = cycle o_fsclk goes 1->0.
//  i_fsdo and i_fscts each pass through 2-flop synchronisers (2-cycle latency). They are sampled only on rise_tick.
//  Frame (both directions): start 0, d[0]..d[7] LSB first, source bit. 10 FSCLK periods. Idle line = 1.
//  TX FSM IDLE->WAIT_CTS->SHIFT->IDLE:
//   IDLE: FIFO non-empty -> pop into shifter, go to WAIT_CTS.
//   WAIT_CTS: rise_tick with cts_sync=1 arms. The next fall_tick drives start bit and enters SHIFT.
//   SHIFT: each fall_tick drives next bit (data, then TX_PORT). The fall_tick after the source bit drives 1 and returns to IDLE.
//   CTS is checked only before start, never mid-frame. CTS low holds o_fsdi=1 indefinitely.
//  RX FSM IDLE->DATA->SRC->IDLE, all on rise_tick:
//   IDLE: fsdo_sync=0 -> DATA.
//   DATA: 8 samples shifted LSB first.
//   SRC: sample source bit, then push {src,byte}.
//  RX push when full: frame dropped, o_rx_overflow=1. Push and pop in the same cycle while full: push accepted.
//  FIFOs are show-ahead. TX write to full FIFO is ignored (ready=0). Pointers wrap modulo depth; a count register (AW+1 bits) distinguishes full from empty.
//  o_rx_valid goes high 1 cycle after the push (registered).
// CONFIGURATION
//  FAST_SERIAL_LOOPBACK_EN defined: i_loopback=1 routes internal FSDI to the RX input (bypassing the synchroniser) and forces CTS=1.
//   o_fsdi is held at 1 while looped.
//  Not defined: i_loopback is ignored. Pins are used directly; the logic is absent.
// TESTING (CLK_DIV=4 unless stated)
//  1. Assert reset 3 cycles -> o_fsdi=1, o_fsclk=0, o_rx_valid=0, o_tx_ready=1, o_rx_overflow=0.
//  2. Write 0xA5, fscts=1 -> FSDI per fall_tick 0,1,0,1,0,0,1,0,1,0, then 1. o_tx_busy falls after the frame.
//  3. Write 0x3C, fscts=0 for 100 cycles -> o_fsdi stays 1. Raise fscts -> start bit within 2 FSCLK periods, byte 0x3C sent.
//  4. Drive FSDO frame (changes on FSCLK falls) 0,0x5A LSB first,src=1 -> o_rx_valid=1, o_rx_data=0x5A, o_rx_src=1.
//  5. RX_AW=2, i_rx_ready=0, send 0x01..0x05 -> 4 entries 0x01..0x04 read back in order, 0x05 lost, o_rx_overflow=1.
//  6. FAST_SERIAL_LOOPBACK_EN, i_loopback=1, write 0x81,0x7E -> RX yields 0x81,0x7E with src=TX_PORT, and o_fsdi stays 1.

Source files
------------

// File: rtl/fast_serial_link.sv
// fast_serial_link
//   FTDI fast-opto serial transceiver. Generates FSCLK from the system clock,
//   serialises queued TX bytes onto FSDI once FSCTS allows, and deserialises
//   FSDO frames into a receive queue. Both directions are buffered in
//   show-ahead FIFOs with valid/ready stream handshakes.
//   Line frame (both directions): start 0, d[0]..d[7] LSB first, source bit;
//   the idle line is 1.
//
// Optional feature macro: FAST_SERIAL_LOOPBACK_EN
//   When defined, i_loopback=1 feeds the internal FSDI straight into the RX
//   deserialiser, forces CTS true and holds the o_fsdi pin at 1.
//   When undefined, i_loopback is ignored and the pins are used directly.
//
// Parameters
//   CLK_DIV  i_clk cycles per FSCLK period (even, >= 4)
//   TX_AW    TX FIFO address width (depth 2**TX_AW)
//   RX_AW    RX FIFO address width (depth 2**RX_AW)
//   TX_PORT  source bit appended to every transmitted frame
//
// Ports
//   i_clk, i_reset              system clock, synchronous active-high reset
//   i_tx_data/valid, o_tx_ready TX byte stream into the TX FIFO
//   o_tx_busy                   TX FIFO non-empty or frame in progress
//   o_rx_data/src/valid         RX FIFO head (byte and its source bit)
//   i_rx_ready                  pops the RX FIFO head when valid
//   o_rx_overflow               sticky: a received frame was dropped
//   o_fsclk, o_fsdi             clock and data to the FTDI device
//   i_fsdo, i_fscts             asynchronous data and clear-to-send from FTDI
//   i_loopback                  loopback select (loopback builds only)

module fast_serial_link #(
  parameter int CLK_DIV = 4,
  parameter int TX_AW   = 4,
  parameter int RX_AW   = 4,
  parameter bit TX_PORT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_busy,
  output logic [7:0] o_rx_data,
  output logic       o_rx_src,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_overflow,
  output logic       o_fsclk,
  output logic       o_fsdi,
  input  logic       i_fsdo,
  input  logic       i_fscts,
  input  logic       i_loopback
);

  localparam int CW       = $clog2(CLK_DIV);
  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(CLK_DIV - 1);
  localparam logic [TX_AW:0] TX_FULL = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_AW:0] RX_FULL = {1'b1, {RX_AW{1'b0}}};

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_CTS, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_SRC} rx_state_t;

  logic [CW-1:0] div_cnt;
  logic          fsclk;
  logic          rise_tick, fall_tick;
  logic          fsdo_meta, fsdo_sync, cts_meta, cts_sync;
  logic          rx_line, cts_ok, tx_line;

  // Divider: ticks mark the cycle whose closing edge moves FSCLK.
  assign rise_tick = (div_cnt == RISE_AT);
  assign fall_tick = (div_cnt == FALL_AT);
  assign o_fsclk   = fsclk;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt <= '0;
      fsclk   <= 1'b0;
    end else begin
      div_cnt <= fall_tick ? '0 : div_cnt + 1'b1;
      if (rise_tick)
        fsclk <= 1'b1;
      else if (fall_tick)
        fsclk <= 1'b0;
    end
  end

  // Two-flop synchronisers; FSDO idles high, CTS idles deasserted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fsdo_meta <= 1'b1;
      fsdo_sync <= 1'b1;
      cts_meta  <= 1'b0;
      cts_sync  <= 1'b0;
    end else begin
      fsdo_meta <= i_fsdo;
      fsdo_sync <= fsdo_meta;
      cts_meta  <= i_fscts;
      cts_sync  <= cts_meta;
    end
  end

`ifdef FAST_SERIAL_LOOPBACK_EN
  // Loopback takes the registered TX line directly, so no synchroniser delay.
  assign rx_line = i_loopback ? tx_line : fsdo_sync;
  assign cts_ok  = i_loopback | cts_sync;
  assign o_fsdi  = i_loopback ? 1'b1 : tx_line;
`else
  logic unused_loopback;
  assign unused_loopback = i_loopback;
  assign rx_line = fsdo_sync;
  assign cts_ok  = cts_sync;
  assign o_fsdi  = tx_line;
`endif

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_push, tx_pop;
  tx_state_t        tx_state;
  logic [8:0]       tx_shift;
  logic [3:0]       tx_bits;
  logic             tx_armed;

  assign o_tx_ready = (tx_count != TX_FULL);
  assign tx_push    = i_tx_valid && o_tx_ready;
  assign tx_pop     = (tx_state == TX_IDLE) && (tx_count != '0);
  assign o_tx_busy  = (tx_count != '0) || (tx_state != TX_IDLE);

  always_ff @(posedge i_clk) begin
    if (tx_push)
      tx_mem[tx_wr_ptr] <= i_tx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push)
        tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)
        tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX FSM: CTS is only consulted before the start bit; once armed the whole
  // frame goes out. Every line change happens on a falling FSCLK edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state <= TX_IDLE;
      tx_line  <= 1'b1;
      tx_shift <= '0;
      tx_bits  <= '0;
      tx_armed <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_count != '0) begin
            tx_shift <= {TX_PORT, tx_mem[tx_rd_ptr]};
            tx_armed <= 1'b0;
            tx_state <= TX_WAIT_CTS;
          end
        end
        TX_WAIT_CTS: begin
          if (rise_tick && cts_ok) begin
            tx_armed <= 1'b1;
          end else if (fall_tick && tx_armed) begin
            tx_line  <= 1'b0;
            tx_bits  <= '0;
            tx_state <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (fall_tick) begin
            if (tx_bits == 4'd9) begin
              tx_line  <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_line  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[8:1]};
              tx_bits  <= tx_bits + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  rx_state_t        rx_state;
  logic [7:0]       rx_shift;
  logic [2:0]       rx_bits;
  logic [8:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_push, rx_pop, rx_full, rx_accept;

  // RX FSM: all sampling on rising FSCLK edges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_bits  <= '0;
    end else if (rise_tick) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_line) begin
            rx_bits  <= '0;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          rx_shift <= {rx_line, rx_shift[7:1]};
          rx_bits  <= rx_bits + 1'b1;
          if (rx_bits == 3'd7)
            rx_state <= RX_SRC;
        end
        RX_SRC:  rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO that
  // is being drained is still accepted.
  assign rx_push    = rise_tick && (rx_state == RX_SRC);
  assign rx_full    = (rx_count == RX_FULL);
  assign rx_pop     = o_rx_valid && i_rx_ready;
  assign rx_accept  = rx_push && (!rx_full || rx_pop);
  assign o_rx_valid = (rx_count != '0);
  assign o_rx_data  = rx_mem[rx_rd_ptr][7:0];
  assign o_rx_src   = rx_mem[rx_rd_ptr][8];

  always_ff @(posedge i_clk) begin
    if (rx_accept)
      rx_mem[rx_wr_ptr] <= {rx_line, rx_shift};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      rx_count      <= '0;
      o_rx_overflow <= 1'b0;
    end else begin
      if (rx_accept)
        rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)
        rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_accept, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      if (rx_push && !rx_accept)
        o_rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fast_serial_link.sv
// tb_fast_serial_link
//   Self-checking bench for fast_serial_link (CLK_DIV=4, TX_AW=4, RX_AW=2).
//   A line monitor records FSDI at every FSCLK fall and decodes whole frames;
//   an FSDO driver plays frames into the receiver. Expected values come from
//   constant tables and from queues of the bytes the bench itself generated.

module tb_fast_serial_link;

  localparam int CLK_DIV = 4;
  localparam int TX_AW   = 4;
  localparam int RX_AW   = 2;
  localparam bit TX_PORT = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       src;
    logic [9:0] line;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready, o_tx_busy;
  logic [7:0] o_rx_data;
  logic       o_rx_src, o_rx_valid;
  logic       i_rx_ready;
  logic       o_rx_overflow, o_fsclk, o_fsdi;
  logic       i_fsdo, i_fscts, i_loopback;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fast_serial_link #(
    .CLK_DIV(CLK_DIV), .TX_AW(TX_AW), .RX_AW(RX_AW), .TX_PORT(TX_PORT)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready), .o_tx_busy(o_tx_busy),
    .o_rx_data(o_rx_data), .o_rx_src(o_rx_src), .o_rx_valid(o_rx_valid),
    .i_rx_ready(i_rx_ready), .o_rx_overflow(o_rx_overflow),
    .o_fsclk(o_fsclk), .o_fsdi(o_fsdi),
    .i_fsdo(i_fsdo), .i_fscts(i_fscts), .i_loopback(i_loopback)
  );

  // Line monitor: raw FSDI per FSCLK fall plus a frame decoder.
  int         fall_count = 0;
  logic       fsclk_prev = 1'b0;
  logic       line_q[$];
  logic [8:0] dec_q[$];
  int         dec_bit = -1;
  logic [8:0] dec_acc = '0;
  bit         fsdi_low_seen = 1'b0;

  always @(posedge clk) begin
    #1;
    if (o_fsdi === 1'b0) fsdi_low_seen = 1'b1;
    if (reset) begin
      dec_bit = -1;
    end else if (fsclk_prev && !o_fsclk) begin
      fall_count++;
      line_q.push_back(o_fsdi);
      if (dec_bit < 0) begin
        if (!o_fsdi) dec_bit = 0;
      end else begin
        dec_acc[dec_bit] = o_fsdi;
        dec_bit++;
        if (dec_bit == 9) begin
          dec_q.push_back(dec_acc);
          dec_bit = -1;
        end
      end
    end
    fsclk_prev = o_fsclk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  task automatic waitFall();
    int start;
    int guard;
    start = fall_count;
    guard = 0;
    while (fall_count == start && guard < 50) begin
      tick(1);
      guard++;
    end
    if (fall_count == start) reportTimeout("fsclk_fall");
  endtask

  // Write one TX byte through the valid/ready handshake.
  task automatic applyStimulus(input logic [7:0] data);
    int guard;
    guard = 0;
    i_tx_data  = data;
    i_tx_valid = 1'b1;
    while (!o_tx_ready && guard < 2000) begin
      tick(1);
      guard++;
    end
    if (!o_tx_ready) reportTimeout("tx_write");
    tick(1);
    i_tx_valid = 1'b0;
  endtask

  function automatic int firstZero();
    foreach (line_q[i]) if (!line_q[i]) return i;
    return -1;
  endfunction

  // Collect start..src plus the following idle bit from the raw line record.
  task automatic waitLineFrame(output logic [9:0] bits, output logic trail, output bit ok);
    int s;
    int guard;
    ok = 1'b0;
    bits = '1;
    trail = 1'b0;
    guard = 0;
    s = firstZero();
    while ((s < 0 || line_q.size() < s + 11) && guard < 40) begin
      waitFall();
      guard++;
      s = firstZero();
    end
    if (s >= 0 && line_q.size() >= s + 11) begin
      for (int i = 0; i < 10; i++) bits[i] = line_q[s + i];
      trail = line_q[s + 10];
      ok = 1'b1;
    end else begin
      reportTimeout("tx_frame");
    end
  endtask

  // Drive one FSDO frame, changing the line just after FSCLK falls.
  task automatic sendFrame(input logic [7:0] data, input logic src);
    logic [9:0] bits;
    bits = {src, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      waitFall();
      i_fsdo = bits[i];
    end
    waitFall();
    i_fsdo = 1'b1;
  endtask

  task automatic popRx(output logic [7:0] data, output logic src);
    int guard;
    guard = 0;
    data = '0;
    src = 1'b0;
    while (!o_rx_valid && guard < 300) begin
      tick(1);
      guard++;
    end
    if (!o_rx_valid) begin
      reportTimeout("rx_valid");
    end else begin
      data = o_rx_data;
      src = o_rx_src;
      i_rx_ready = 1'b1;
      tick(1);
      i_rx_ready = 1'b0;
    end
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] got_data, b;
    logic       got_src, got_trail, s;
    logic [9:0] got_line;
    bit         ok;
    logic [8:0] exp_q[$];
    int         guard, f0, n;

    vecs[0] = '{8'hA5, 1'b1, 10'b0_10100101_0};
    vecs[1] = '{8'h5A, 1'b1, 10'b0_01011010_0};
    vecs[2] = '{8'h3C, 1'b0, 10'b0_00111100_0};
    vecs[3] = '{8'hFF, 1'b1, 10'b0_11111111_0};
    vecs[4] = '{8'h00, 1'b0, 10'b0_00000000_0};
    vecs[5] = '{8'h81, 1'b1, 10'b0_10000001_0};

    reset = 1'b1;
    i_tx_data = '0;
    i_tx_valid = 1'b0;
    i_rx_ready = 1'b0;
    i_fsdo = 1'b1;
    i_fscts = 1'b1;
    i_loopback = 1'b0;

    $display("[TB] reset state");
    tick(3);
    checkOutput("reset_fsdi", o_fsdi, 1);
    checkOutput("reset_fsclk", o_fsclk, 0);
    checkOutput("reset_rx_valid", o_rx_valid, 0);
    checkOutput("reset_tx_ready", o_tx_ready, 1);
    checkOutput("reset_rx_overflow", o_rx_overflow, 0);
    checkOutput("reset_tx_busy", o_tx_busy, 0);
    reset = 1'b0;
    tick(4);

    $display("[TB] vector table: TX line and RX decode");
    for (int v = 0; v < 6; v++) begin
      line_q.delete();
      applyStimulus(vecs[v].data);
      waitLineFrame(got_line, got_trail, ok);
      if (ok) begin
        checkOutput($sformatf("tx_line_%0d", v), got_line, vecs[v].line);
        checkOutput($sformatf("tx_idle_after_%0d", v), got_trail, 1);
        checkOutput($sformatf("tx_busy_after_%0d", v), o_tx_busy, 0);
      end
      sendFrame(vecs[v].data, vecs[v].src);
      popRx(got_data, got_src);
      checkOutput($sformatf("rx_data_%0d", v), got_data, vecs[v].data);
      checkOutput($sformatf("rx_src_%0d", v), got_src, vecs[v].src);
    end

    $display("[TB] CTS gating");
    i_fscts = 1'b0;
    tick(6);
    line_q.delete();
    fsdi_low_seen = 1'b0;
    applyStimulus(8'h3C);
    tick(100);
    checkOutput("cts_hold_line", fsdi_low_seen, 0);
    checkOutput("cts_hold_busy", o_tx_busy, 1);
    f0 = fall_count;
    i_fscts = 1'b1;
    guard = 0;
    while (firstZero() < 0 && guard < 10) begin
      waitFall();
      guard++;
    end
    if (firstZero() < 0) reportTimeout("cts_start");
    else checkOutput("cts_start_within_2", (fall_count - f0) <= 2, 1);
    waitLineFrame(got_line, got_trail, ok);
    if (ok) checkOutput("cts_line", got_line, 10'b0_00111100_0);

    $display("[TB] random TX burst into full FIFO");
    i_fscts = 1'b0;
    tick(6);
    dec_q.delete();
    exp_q.delete();
    // One byte moves straight into the shifter, so FIFO depth + 1 fit.
    for (int k = 0; k < 17; k++) begin
      b = 8'($urandom);
      exp_q.push_back({TX_PORT, b});
      applyStimulus(b);
    end
    checkOutput("tx_ready_full", o_tx_ready, 0);
    i_tx_data = 8'hEE;
    i_tx_valid = 1'b1;
    tick(3);
    i_tx_valid = 1'b0;
    i_fscts = 1'b1;
    guard = 0;
    while (dec_q.size() < 17 && guard < 300) begin
      waitFall();
      guard++;
    end
    tick(60);
    checkOutput("tx_frame_count", dec_q.size(), 17);
    for (int k = 0; k < 17; k++)
      if (k < dec_q.size()) checkOutput($sformatf("tx_rand_%0d", k), dec_q[k], exp_q[k]);
    checkOutput("tx_busy_drained", o_tx_busy, 0);

    $display("[TB] random RX batches");
    for (int bt = 0; bt < 5; bt++) begin
      n = $urandom_range(1, 4);
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        s = 1'($urandom);
        exp_q.push_back({s, b});
        sendFrame(b, s);
      end
      for (int k = 0; k < n; k++) begin
        popRx(got_data, got_src);
        checkOutput($sformatf("rx_rand_%0d_%0d", bt, k), {got_src, got_data}, exp_q[k]);
      end
    end
    checkOutput("rx_no_overflow", o_rx_overflow, 0);

    $display("[TB] RX overflow");
    for (int k = 1; k <= 5; k++) begin
      sendFrame(8'(k), 1'b0);
      if (k == 4) begin
        tick(8);
        checkOutput("rx_overflow_at_full", o_rx_overflow, 0);
      end
    end
    tick(10);
    checkOutput("rx_overflow_set", o_rx_overflow, 1);
    for (int k = 1; k <= 4; k++) begin
      popRx(got_data, got_src);
      checkOutput($sformatf("rx_ovf_order_%0d", k), got_data, k);
    end
    tick(2);
    checkOutput("rx_empty_after_drain", o_rx_valid, 0);
    checkOutput("rx_overflow_sticky", o_rx_overflow, 1);

`ifdef FAST_SERIAL_LOOPBACK_EN
    $display("[TB] loopback");
    i_loopback = 1'b1;
    i_fscts = 1'b0;
    tick(2);
    fsdi_low_seen = 1'b0;
    applyStimulus(8'h81);
    applyStimulus(8'h7E);
    popRx(got_data, got_src);
    checkOutput("loop_data_0", got_data, 8'h81);
    checkOutput("loop_src_0", got_src, TX_PORT);
    popRx(got_data, got_src);
    checkOutput("loop_data_1", got_data, 8'h7E);
    checkOutput("loop_src_1", got_src, TX_PORT);
    checkOutput("loop_fsdi_held", fsdi_low_seen, 0);
    tick(20);
    i_loopback = 1'b0;
    i_fscts = 1'b1;
    tick(6);
`endif

    $display("[TB] reset mid-frame");
    line_q.delete();
    applyStimulus(8'h00);
    guard = 0;
    while (firstZero() < 0 && guard < 10) begin
      waitFall();
      guard++;
    end
    if (firstZero() < 0) reportTimeout("midframe_start");
    waitFall();
    waitFall();
    waitFall();
    checkOutput("midframe_line_low", o_fsdi, 0);
    reset = 1'b1;
    tick(1);
    checkOutput("midreset_fsdi", o_fsdi, 1);
    checkOutput("midreset_busy", o_tx_busy, 0);
    checkOutput("midreset_fsclk", o_fsclk, 0);
    checkOutput("midreset_overflow", o_rx_overflow, 0);
    checkOutput("midreset_tx_ready", o_tx_ready, 1);
    reset = 1'b0;
    fsdi_low_seen = 1'b0;
    tick(40);
    checkOutput("after_reset_idle", fsdi_low_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
